core_lsu: RTL and testbench
===========================

// Module: core_lsu
// PURPOSE
//  Parametrised load/store unit between core execute stage and data memory.
//  Generalises the core's 2-bit mem_stage tracker to up to max_out_p in-order outstanding
//  requests, byte/half/word(/dword) sizes with byte enables, sign/zero-extended loads,
//  and a sticky exception on misaligned or illegal accesses and unsolicited responses.
// PARAMETERS
//  data_width_p  32  memory data width; multiple of 8, lanes_lp = data_width_p/8 (power of 2)
//  addr_width_p  32  byte address width
//  rd_width_p    5   destination register tag width
//  max_out_p     2   max in-order outstanding requests (tracking FIFO depth, >=1)
// PORTS
//  clk          in   1             clock
//  reset        in   1             synchronous, active-high reset
//  req_valid_i  in   1             core presents LD/ST request
//  req_ready_o  out  1             request consumed this cycle
//  req_wen_i    in   1             1 = store, 0 = load
//  req_size_i   in   2             log2(bytes): 0 byte, 1 half, 2 word, 3 dword
//  req_signed_i in   1             load sign-extends when 1
//  req_addr_i   in   addr_width_p  byte address
//  req_wdata_i  in   data_width_p  store data, LSB-aligned
//  req_rd_i     in   rd_width_p    load destination tag
//  mem_valid_o  out  1             request to memory
//  mem_yumi_i   in   1             memory accepted request
//  mem_addr_o   out  addr_width_p  address, low log2(lanes_lp) bits forced 0
//  mem_wen_o    out  1             store
//  mem_be_o     out  lanes_lp      byte enables
//  mem_wdata_o  out  data_width_p  store data replicated to all lanes
//  mem_valid_i  in   1             memory response (loads and stores)
//  mem_rdata_i  in   data_width_p  response data
//  mem_yumi_o   out  1             response consumed
//  resp_valid_o out  1             formatted response to core
//  resp_wen_o   out  1             response belongs to a store
//  resp_rd_o    out  rd_width_p    load destination tag
//  resp_data_o  out  data_width_p  aligned, extended load data (0 for stores)
//  resp_yumi_i  in   1             core commits response (drives mem_yumi_o)
//  busy_o       out  1             outstanding count != 0
//  exception_o  out  1             sticky error flag
// BEHAVIOUR
//  Reset: count 0, FIFO empty, exception_o 0; so resp_valid_o 0, busy_o 0, mem_valid_o 0.
//  legal = (1<<size) <= lanes_lp and addr mod (1<<size) == 0.
//  Issue (comb): mem_valid_o = req_valid_i & legal & count<max_out_p & ~exception_o.
//  req_ready_o = mem_valid_o & mem_yumi_i, OR (req_valid_i & ~legal & ~exception_o).
//  Illegal req: consumed and dropped, no memory access; exception_o =1 next cycle.
//  Push {wen,size,signed,offset,rd} to FIFO on mem_valid_o & mem_yumi_i; count+1.
//  mem_be_o: ((1<<(1<<size))-1) << offset, offset = addr[log2(lanes_lp)-1:0].
//  Response (comb): resp_valid_o = mem_valid_i & count!=0; fields from FIFO head.
//  Load data: rdata >> (8*offset), truncated to 8<<size bits, sign- or zero-extended.
//  mem_yumi_o = resp_valid_o & resp_yumi_i; pop FIFO, count-1 on that event.
//  Same-cycle push and pop: count unchanged; FIFO pointers wrap mod max_out_p.
//  Full (count==max_out_p): mem_valid_o 0, req_ready_o 0 for legal reqs, no push.
//  Unsolicited mem_valid_i with count==0: mem_yumi_o=1 (drain), exception_o set next cycle.
//  exception_o sticky until reset; blocks new issue; outstanding responses still drain.
//  Latency: request->memory 0 cycles; response->core 0 cycles (purely comb path).
//  Reset mid-operation: FIFO and count cleared; later responses count as unsolicited.
// TESTING
//  LW addr 0x8, rd=3; mem returns 0xDEADBEEF -> be=4'b1111, resp_data 0xDEADBEEF, rd 3.
//  LB signed addr 0x3, rdata 0x80_00_00_00 -> be=4'b1000, resp_data 0xFFFFFF80; unsigned 0x80.
//  SH addr 0x2, wdata 0x1234 -> be=4'b1100, mem_wdata 0x12341234, resp_wen 1, data 0.
//  max_out_p=2, three back-to-back LWs with memory delaying responses -> third stalls
//   (req_ready_o 0) until first resp_yumi_i; responses return in order; busy_o tracks count.
//  LW addr 0x6 -> no mem_valid_o, req_ready_o 1, exception_o 1 next cycle and held.
//  mem_valid_i with nothing outstanding -> mem_yumi_o 1, resp_valid_o 0, exception_o 1.

Source files
------------

// File: rtl/core_lsu.sv
// Load/store unit: issues byte/half/word requests to memory and formats in-order responses.
// Latency: request->memory and memory response->core are both purely combinational (0 cycles).
// Backpressure: stalls req_ready_o when max_out_p requests are outstanding, memory withholds mem_yumi_i, or an exception is latched.
module core_lsu #(
  parameter int data_width_p = 32,
  parameter int addr_width_p = 32,
  parameter int rd_width_p   = 5,
  parameter int max_out_p    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_wen_i,
  input  logic [1:0]                req_size_i,
  input  logic                      req_signed_i,
  input  logic [addr_width_p-1:0]   req_addr_i,
  input  logic [data_width_p-1:0]   req_wdata_i,
  input  logic [rd_width_p-1:0]     req_rd_i,
  output logic                      mem_valid_o,
  input  logic                      mem_yumi_i,
  output logic [addr_width_p-1:0]   mem_addr_o,
  output logic                      mem_wen_o,
  output logic [data_width_p/8-1:0] mem_be_o,
  output logic [data_width_p-1:0]   mem_wdata_o,
  input  logic                      mem_valid_i,
  input  logic [data_width_p-1:0]   mem_rdata_i,
  output logic                      mem_yumi_o,
  output logic                      resp_valid_o,
  output logic                      resp_wen_o,
  output logic [rd_width_p-1:0]     resp_rd_o,
  output logic [data_width_p-1:0]   resp_data_o,
  input  logic                      resp_yumi_i,
  output logic                      busy_o,
  output logic                      exception_o
);

  localparam int lanes_lp = data_width_p / 8;
  localparam int off_w_lp = (lanes_lp > 1) ? $clog2(lanes_lp) : 1;
  localparam int ptr_w_lp = (max_out_p > 1) ? $clog2(max_out_p) : 1;
  localparam int cnt_w_lp = $clog2(max_out_p + 1);
  localparam logic [off_w_lp-1:0]     off_mask_lp  = off_w_lp'(lanes_lp - 1);
  localparam logic [addr_width_p-1:0] addr_mask_lp = ~addr_width_p'(lanes_lp - 1);

  // Per-request bookkeeping needed to format the matching response.
  typedef struct packed {
    logic                  wen;
    logic [1:0]            size;
    logic                  sgn;
    logic [off_w_lp-1:0]   offset;
    logic [rd_width_p-1:0] rd;
  } entry_t;

  entry_t                  fifo_mem [max_out_p];
  entry_t                  push_entry;
  entry_t                  head;
  logic [ptr_w_lp-1:0]     wr_ptr;
  logic [ptr_w_lp-1:0]     rd_ptr;
  logic [cnt_w_lp-1:0]     count;

  logic [3:0]              req_bytes;
  logic [2:0]              align_mask;
  logic                    legal;
  logic [off_w_lp-1:0]     req_off;
  logic [lanes_lp-1:0]     size_be;
  logic                    not_full;
  logic                    push;
  logic                    pop;
  logic                    drop;
  logic                    unsolicited;
  logic [data_width_p-1:0] shifted;
  logic [data_width_p-1:0] load_data;
  int                      msb;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(max_out_p - 1)) ? '0 : p + 1'b1;
  endfunction

  // Decode the request: legality, lane offset, byte enables and lane-replicated store data.
  always_comb begin
    req_bytes  = 4'd1 << req_size_i;
    align_mask = {req_size_i == 2'd3, req_size_i >= 2'd2, req_size_i != 2'd0};
    legal      = (int'(req_bytes) <= lanes_lp) && ((req_addr_i[2:0] & align_mask) == 3'd0);
    req_off    = req_addr_i[off_w_lp-1:0] & off_mask_lp;
    size_be    = '0;
    for (int i = 0; i < lanes_lp; i++) begin
      size_be[i] = (i < int'(req_bytes));
    end
    mem_be_o    = size_be << req_off;
    mem_wdata_o = '0;
    for (int j = 0; j < lanes_lp; j++) begin
      mem_wdata_o[8*j +: 8] = req_wdata_i[8*(j & (int'(req_bytes) - 1)) +: 8];
    end
  end

  // Issue handshake: illegal requests are swallowed without touching memory.
  always_comb begin
    not_full    = count < cnt_w_lp'(max_out_p);
    mem_valid_o = req_valid_i & legal & not_full & ~exception_o;
    push        = mem_valid_o & mem_yumi_i;
    drop        = req_valid_i & ~legal & ~exception_o;
    req_ready_o = push | drop;
    mem_addr_o  = req_addr_i & addr_mask_lp;
    mem_wen_o   = req_wen_i;
    push_entry  = '{wen: req_wen_i, size: req_size_i, sgn: req_signed_i,
                    offset: req_off, rd: req_rd_i};
  end

  // Response handshake: responses with nothing outstanding are drained and flagged.
  always_comb begin
    head         = fifo_mem[rd_ptr];
    resp_valid_o = mem_valid_i & (count != '0);
    pop          = resp_valid_o & resp_yumi_i;
    unsolicited  = mem_valid_i & (count == '0);
    mem_yumi_o   = pop | unsolicited;
    resp_wen_o   = head.wen;
    resp_rd_o    = head.rd;
    busy_o       = count != '0;
  end

  // Align the returned lane to bit 0, truncate to the access size, then sign/zero extend.
  always_comb begin
    shifted = mem_rdata_i >> {head.offset, 3'b000};
    msb     = (8 << head.size) - 1;
    if (msb > data_width_p - 1) msb = data_width_p - 1;
    load_data = '0;
    for (int b = 0; b < data_width_p; b++) begin
      load_data[b] = (b <= msb) ? shifted[b] : (head.sgn & shifted[msb]);
    end
    resp_data_o = head.wen ? '0 : load_data;
  end

  // Tracking storage; contents are only meaningful between push and pop.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= push_entry;
  end

  // Pointers, outstanding count and the sticky exception flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      exception_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (drop || unsolicited) exception_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_core_lsu.sv
// Randomised + directed bench for core_lsu against a queue-based reference model.
// Inputs are driven 1 time unit after posedge, outputs sampled 4 units later.
// The model advances its state at each posedge from the handshakes it predicted.
module tb_core_lsu;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_wen, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        req_ready_o, mem_valid_o, mem_wen_o, mem_yumi_o;
  logic        mem_yumi_in, mem_valid_in, resp_yumi;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata;
  logic [3:0]  mem_be_o;
  logic        resp_valid_o, resp_wen_o, busy_o, exception_o;
  logic [4:0]  resp_rd_o;
  logic [31:0] resp_data_o;

  core_lsu dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_wen_i(req_wen),
    .req_size_i(req_size), .req_signed_i(req_signed), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_rd_i(req_rd),
    .mem_valid_o(mem_valid_o), .mem_yumi_i(mem_yumi_in), .mem_addr_o(mem_addr_o),
    .mem_wen_o(mem_wen_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_valid_i(mem_valid_in), .mem_rdata_i(mem_rdata), .mem_yumi_o(mem_yumi_o),
    .resp_valid_o(resp_valid_o), .resp_wen_o(resp_wen_o), .resp_rd_o(resp_rd_o),
    .resp_data_o(resp_data_o), .resp_yumi_i(resp_yumi),
    .busy_o(busy_o), .exception_o(exception_o)
  );

  always #5 clk = ~clk;

  typedef struct { bit wen; int size; bit sgn; int off; int rd; } pend_t;
  pend_t m_q[$];
  bit    m_exc;
  int    n_checks = 0;
  int    n_fail   = 0;

  // values sampled in the last cycle, for directed literal checks
  logic        o_mem_valid, o_req_ready, o_resp_valid, o_resp_wen, o_mem_yumi, o_busy, o_exc;
  logic [3:0]  o_be;
  logic [4:0]  o_resp_rd;
  logic [31:0] o_wdata, o_resp_data, o_mem_addr;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit legal(input int size, input logic [31:0] addr);
    int bytes = 1 << size;
    return (bytes <= 4) && ((addr % bytes) == 0);
  endfunction

  function automatic logic [3:0] exp_be(input int size, input int off);
    logic [7:0] b = ((8'd1 << (1 << size)) - 8'd1) << off;
    return b[3:0];
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [31:0] wd, input int size);
    int w = 8 << size;
    logic [63:0] pat = {32'd0, wd} & ((64'd1 << w) - 64'd1);
    logic [63:0] rep = 64'd0;
    for (int k = 0; k < 32 / w; k++) rep = rep | (pat << (k * w));
    return rep[31:0];
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] rd, input int size, input bit sgn, input int off);
    int w = 8 << size;
    logic [63:0] m = (64'd1 << w) - 64'd1;
    logic [63:0] v = ({32'd0, rd} >> (8 * off)) & m;
    if (sgn && v[w-1]) v = v | ~m;
    return v[31:0];
  endfunction

  task automatic idle();
    req_valid = 0; req_wen = 0; req_size = 0; req_signed = 0; req_addr = 0;
    req_wdata = 0; req_rd = 0; mem_yumi_in = 0; mem_valid_in = 0; mem_rdata = 0; resp_yumi = 0;
  endtask

  task automatic set_req(input bit wen, input int size, input bit sgn, input logic [31:0] addr,
                         input logic [31:0] wd, input int rd);
    req_valid = 1; req_wen = wen; req_size = 2'(size); req_signed = sgn;
    req_addr = addr; req_wdata = wd; req_rd = 5'(rd); mem_yumi_in = 1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    @(posedge clk); #1;
    m_q.delete();
    m_exc = 0;
    reset = 0;
  endtask

  // One clock: check combinational outputs against the model, then advance the model.
  task automatic run_cycle();
    int    cnt;
    bit    lg, e_mv, e_rr, e_rv, e_my, e_push, e_pop, exc_next;
    pend_t h, n;
    #4;
    cnt  = m_q.size();
    lg   = legal(int'(req_size), req_addr);
    e_mv = req_valid && lg && (cnt < 2) && !m_exc;
    e_rr = (e_mv && mem_yumi_in) || (req_valid && !lg && !m_exc);
    e_rv = mem_valid_in && (cnt != 0);
    e_my = (e_rv && resp_yumi) || (mem_valid_in && cnt == 0);
    e_push = e_mv && mem_yumi_in;
    e_pop  = e_rv && resp_yumi;
    exc_next = m_exc || (req_valid && !lg && !m_exc) || (mem_valid_in && cnt == 0);

    check_eq("mem_valid_o", mem_valid_o, e_mv);
    check_eq("req_ready_o", req_ready_o, e_rr);
    check_eq("resp_valid_o", resp_valid_o, e_rv);
    check_eq("mem_yumi_o", mem_yumi_o, e_my);
    check_eq("busy_o", busy_o, cnt != 0);
    check_eq("exception_o", exception_o, m_exc);
    if (e_mv) begin
      check_eq("mem_addr_o", mem_addr_o, req_addr & ~32'd3);
      check_eq("mem_be_o", mem_be_o, exp_be(int'(req_size), int'(req_addr[1:0])));
      check_eq("mem_wen_o", mem_wen_o, req_wen);
      if (req_wen) check_eq("mem_wdata_o", mem_wdata_o, exp_wdata(req_wdata, int'(req_size)));
    end
    if (e_rv) begin
      h = m_q[0];
      check_eq("resp_wen_o", resp_wen_o, h.wen);
      if (!h.wen) check_eq("resp_rd_o", resp_rd_o, h.rd);
      check_eq("resp_data_o", resp_data_o, h.wen ? 32'd0 : exp_load(mem_rdata, h.size, h.sgn, h.off));
    end

    o_mem_valid = mem_valid_o; o_req_ready = req_ready_o; o_resp_valid = resp_valid_o;
    o_resp_wen = resp_wen_o; o_mem_yumi = mem_yumi_o; o_busy = busy_o; o_exc = exception_o;
    o_be = mem_be_o; o_resp_rd = resp_rd_o; o_wdata = mem_wdata_o; o_resp_data = resp_data_o;
    o_mem_addr = mem_addr_o;

    @(posedge clk);
    if (e_pop) void'(m_q.pop_front());
    if (e_push) begin
      n.wen = req_wen; n.size = int'(req_size); n.sgn = req_signed;
      n.off = int'(req_addr[1:0]); n.rd = int'(req_rd);
      m_q.push_back(n);
    end
    m_exc = exc_next;
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int sz;
    idle();
    do_reset();
    do_reset();

    // reset state
    run_cycle();
    check_eq("rst_busy", o_busy, 0);
    check_eq("rst_exc", o_exc, 0);
    check_eq("rst_resp_valid", o_resp_valid, 0);
    check_eq("rst_mem_valid", o_mem_valid, 0);

    // LW addr 0x8 rd 3
    idle(); set_req(0, 2, 0, 32'h8, 0, 3); run_cycle();
    check_eq("lw_be", o_be, 4'b1111);
    check_eq("lw_ready", o_req_ready, 1);
    idle(); mem_valid_in = 1; mem_rdata = 32'hDEADBEEF; resp_yumi = 1; run_cycle();
    check_eq("lw_data", o_resp_data, 32'hDEADBEEF);
    check_eq("lw_rd", o_resp_rd, 3);

    // LB signed / unsigned at addr 0x3
    idle(); set_req(0, 0, 1, 32'h3, 0, 7); run_cycle();
    check_eq("lb_be", o_be, 4'b1000);
    idle(); mem_valid_in = 1; mem_rdata = 32'h8000_0000; resp_yumi = 1; run_cycle();
    check_eq("lb_signed", o_resp_data, 32'hFFFF_FF80);
    idle(); set_req(0, 0, 0, 32'h3, 0, 8); run_cycle();
    idle(); mem_valid_in = 1; mem_rdata = 32'h8000_0000; resp_yumi = 1; run_cycle();
    check_eq("lb_unsigned", o_resp_data, 32'h80);

    // SH addr 0x2
    idle(); set_req(1, 1, 0, 32'h2, 32'h1234, 0); run_cycle();
    check_eq("sh_be", o_be, 4'b1100);
    check_eq("sh_wdata", o_wdata, 32'h12341234);
    idle(); mem_valid_in = 1; mem_rdata = 32'hFFFFFFFF; resp_yumi = 1; run_cycle();
    check_eq("sh_resp_wen", o_resp_wen, 1);
    check_eq("sh_resp_data", o_resp_data, 0);

    // three back-to-back LWs with max_out_p=2
    idle(); set_req(0, 2, 0, 32'h10, 0, 1); run_cycle();
    set_req(0, 2, 0, 32'h14, 0, 2); run_cycle();
    check_eq("b2b_busy", o_busy, 1);
    set_req(0, 2, 0, 32'h18, 0, 3); run_cycle();
    check_eq("full_ready", o_req_ready, 0);
    check_eq("full_mem_valid", o_mem_valid, 0);
    mem_valid_in = 1; mem_rdata = 32'hA1; resp_yumi = 1; run_cycle();
    check_eq("full_ready_pop", o_req_ready, 0);
    check_eq("order_rd1", o_resp_rd, 1);
    mem_rdata = 32'hA2; run_cycle();
    check_eq("third_issues", o_req_ready, 1);
    check_eq("order_rd2", o_resp_rd, 2);
    idle(); mem_valid_in = 1; mem_rdata = 32'hA3; resp_yumi = 1; run_cycle();
    check_eq("order_rd3", o_resp_rd, 3);
    check_eq("order_data3", o_resp_data, 32'hA3);
    idle(); run_cycle();
    check_eq("drained_busy", o_busy, 0);

    // misaligned LW addr 0x6
    idle(); set_req(0, 2, 0, 32'h6, 0, 4); run_cycle();
    check_eq("mis_ready", o_req_ready, 1);
    check_eq("mis_mem_valid", o_mem_valid, 0);
    idle(); run_cycle();
    check_eq("mis_exc", o_exc, 1);
    run_cycle();
    check_eq("mis_exc_held", o_exc, 1);

    // unsolicited response
    do_reset();
    idle(); mem_valid_in = 1; mem_rdata = 32'h55; run_cycle();
    check_eq("unsol_yumi", o_mem_yumi, 1);
    check_eq("unsol_resp_valid", o_resp_valid, 0);
    idle(); run_cycle();
    check_eq("unsol_exc", o_exc, 1);

    // reset with a request outstanding
    do_reset();
    idle(); set_req(0, 2, 0, 32'h20, 0, 5); run_cycle();
    do_reset();
    idle(); mem_valid_in = 1; mem_rdata = 32'h66; resp_yumi = 1; run_cycle();
    check_eq("midrst_resp_valid", o_resp_valid, 0);
    idle(); run_cycle();
    check_eq("midrst_exc", o_exc, 1);

    // randomised traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0 || (m_exc && $urandom_range(0, 19) == 0)) begin
        do_reset();
        continue;
      end
      idle();
      sz = ($urandom_range(0, 49) == 0) ? 3 : int'($urandom_range(0, 2));
      req_valid  = ($urandom_range(0, 2) != 0);
      req_wen    = 1'($urandom_range(0, 1));
      req_size   = 2'(sz);
      req_signed = 1'($urandom_range(0, 1));
      req_addr   = $urandom;
      if ($urandom_range(0, 29) != 0) req_addr = req_addr & ~((32'd1 << sz) - 32'd1);
      req_wdata  = $urandom;
      req_rd     = 5'($urandom_range(0, 31));
      mem_yumi_in = ($urandom_range(0, 3) != 0);
      if (m_q.size() != 0) mem_valid_in = 1'($urandom_range(0, 1));
      else                 mem_valid_in = ($urandom_range(0, 99) == 0);
      mem_rdata = $urandom;
      resp_yumi = ($urandom_range(0, 3) != 0);
      run_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
